// File: rtl/i2c_slv_rx_buffer.sv
// i2c_slv_rx_buffer: show-ahead receive FIFO with START/STOP frame tracking and threshold/end-of-frame interrupts.
module i2c_slv_rx_buffer #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o,
  input  logic          flush_i,
  input  logic [LW-1:0] thresh_i,
  input  logic          irq_en_i,
  input  logic [1:0]    irq_clr_i,
  output logic [1:0]    irq_cause_o,
  output logic          irq_o,
  output logic          ovf_o,
  output logic [7:0]    frame_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop, thr_set, eof_set, ovf_q;
  logic [1:0]    cause_q;
  logic [7:0]    cnt_q, cnt_d;
  state_t        state_q, state_d;
  assign pop     = rd_en_i & ~empty_o;
  assign push    = byte_valid_i & (~full_o | pop);
  assign empty_o = level_q == '0;
  assign full_o  = level_q == LW'(DEPTH);
  assign level_d = flush_i ? '0 : level_q + LW'(push) - LW'(pop);
  // only a rising crossing of the threshold raises the cause
  assign thr_set = (thresh_i != '0) & (level_q < thresh_i) & (level_d >= thresh_i);
  assign rd_data_o   = empty_o ? 8'h00 : mem[rd_ptr];
  assign level_o     = level_q;
  assign ovf_o       = ovf_q;
  assign irq_cause_o = cause_q;
  assign irq_o       = irq_en_i & |cause_q;
  assign frame_cnt_o = cnt_q;
  always_ff @(posedge clk_i) begin
    if (push & ~flush_i) mem[wr_ptr] <= byte_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level_q <= level_d;
      ovf_q   <= ovf_q | (byte_valid_i & ~push);
    end
  end
  // STOP takes precedence over a coincident START
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eof_set = 1'b0;
    if (stop_i) begin
      eof_set = (state_q == ACTIVE) & (cnt_q != 8'd0);
      state_d = IDLE;
    end else if (start_i) begin
      eof_set = (state_q == ACTIVE) & (cnt_q != 8'd0);
      state_d = ACTIVE;
      cnt_d   = 8'd0;
    end else if (state_q == ACTIVE && byte_valid_i && cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= (cause_q & ~irq_clr_i) | {eof_set, thr_set};
    end
  end
endmodule

// File: tb/tb_i2c_slv_rx_buffer.sv
// tb_i2c_slv_rx_buffer: queue-based reference model with per-cycle compare, directed scenarios and random traffic.
module tb_i2c_slv_rx_buffer;
  localparam int DEPTH = 8;
  localparam int LW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic bv = 0, st = 0, sp = 0, rd = 0, fl = 0, en = 1;
  logic [7:0] bd = 0;
  logic [LW-1:0] th = 0;
  logic [1:0] clr = 0;
  logic [7:0] rd_data, frame_cnt;
  logic [LW-1:0] level;
  logic empty, full, irq, ovf;
  logic [1:0] cause;
  int passed = 0, total = 0;
  logic [7:0] q[$];
  bit m_ovf, m_act, m_pop, m_push, m_eof, m_thr;
  int m_cnt, m_old;
  logic [1:0] m_cause;
  i2c_slv_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(bv), .byte_data_i(bd),
    .start_i(st), .stop_i(sp), .rd_en_i(rd), .rd_data_o(rd_data),
    .level_o(level), .empty_o(empty), .full_o(full), .flush_i(fl),
    .thresh_i(th), .irq_en_i(en), .irq_clr_i(clr), .irq_cause_o(cause),
    .irq_o(irq), .ovf_o(ovf), .frame_cnt_o(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_act = 0; m_cnt = 0; m_cause = 2'b00;
    end else begin
      m_old  = q.size();
      m_pop  = rd && q.size() > 0;
      m_push = bv && (q.size() < DEPTH || m_pop);
      if (fl) begin
        q.delete();
        m_ovf = 0;
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(bd);
        else if (bv) m_ovf = 1;
      end
      m_thr = th != 0 && m_old < int'(th) && q.size() >= int'(th);
      m_eof = 0;
      if (sp) begin
        m_eof = m_act && m_cnt > 0;
        m_act = 0;
      end else if (st) begin
        m_eof = m_act && m_cnt > 0;
        m_act = 1;
        m_cnt = 0;
      end else if (m_act && bv && m_cnt < 255) m_cnt++;
      m_cause = (m_cause & ~clr) | {m_eof, m_thr};
    end
    #1;
    chk("rd_data", rd_data, q.size() != 0 ? q[0] : 8'h00);
    chk("level", level, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("ovf", ovf, m_ovf);
    chk("cause", cause, m_cause);
    chk("irq", irq, en & |m_cause);
    chk("frame_cnt", frame_cnt, m_cnt);
  end
  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic p,
                       input logic r, input logic f, input logic [1:0] c);
    bv = v; bd = d; st = s; sp = p; rd = r; fl = f; clr = c;
    @(negedge clk);
    bv = 0; st = 0; sp = 0; rd = 0; fl = 0; clr = 0;
  endtask
  task automatic push(input logic [7:0] d); drive(1, d, 0, 0, 0, 0, 0); endtask
  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_data", rd_data, exp);
    drive(0, 0, 0, 0, 1, 0, 0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cause", cause, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // single frame
    drive(0, 0, 1, 0, 0, 0, 0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("sf_cause", cause, 2'b10);
    chk("sf_irq", irq, 1);
    chk("sf_cnt", frame_cnt, 4);
    drive(0, 0, 0, 0, 0, 0, 2'b10);
    pop_chk(8'h11); pop_chk(8'h22); pop_chk(8'h33); pop_chk(8'h44);
    chk("sf_empty", empty, 1);
    // threshold crossing
    th = 3;
    push(8'h01); push(8'h02);
    chk("th_before", cause[0], 0);
    push(8'h03);
    chk("th_set", cause[0], 1);
    drive(0, 0, 0, 0, 0, 0, 2'b01);
    push(8'h04);
    chk("th_hold", cause[0], 0);
    pop_chk(8'h01); pop_chk(8'h02);
    chk("th_level2", level, 2);
    push(8'h05);
    chk("th_reset", cause[0], 1);
    drive(0, 0, 0, 0, 0, 1, 2'b01);
    th = 0;
    // overflow
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) push(8'(i));
    chk("ov_full", full, 1);
    chk("ov_ovf", ovf, 1);
    chk("ov_cnt", frame_cnt, 9);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b10);
    for (int i = 0; i < 8; i++) pop_chk(8'(i));
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("fl_ovf", ovf, 0);
    chk("fl_empty", empty, 1);
    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    drive(1, 8'hAA, 0, 0, 1, 0, 0);
    chk("pp_level", level, 8);
    chk("pp_ovf", ovf, 0);
    for (int i = 1; i < 8; i++) pop_chk(8'h10 + 8'(i));
    pop_chk(8'hAA);
    chk("pp_empty", empty, 1);
    // repeated START
    drive(0, 0, 1, 0, 0, 0, 0);
    push(8'h21); push(8'h22);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("rs_cause", cause[1], 1);
    chk("rs_cnt0", frame_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b10);
    push(8'h23);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("rs_stop", cause[1], 1);
    chk("rs_cnt1", frame_cnt, 1);
    drive(0, 0, 0, 0, 0, 0, 2'b10);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("rs_idle_stop", cause, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // set beats clear
    drive(0, 0, 1, 0, 0, 0, 0);
    push(8'h31);
    drive(0, 0, 0, 1, 0, 0, 2'b10);
    chk("clr_prio", cause[1], 1);
    drive(0, 0, 0, 0, 0, 1, 2'b10);
    // frame count saturation under push+pop streaming
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) drive(1, 8'(i), 0, 0, 1, 0, 0);
    chk("sat_cnt", frame_cnt, 255);
    chk("sat_level", level, 1);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b11);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, p, v;
      s = $urandom_range(0, 99) < 4;
      p = $urandom_range(0, 99) < 4;
      v = !(s || p) && $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 49) == 0) th = LW'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 49) == 0) en = 1'($urandom);
      drive(v, 8'($urandom), s, p, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2,
            $urandom_range(0, 9) == 0 ? 2'($urandom) : 2'b00);
    end
    drive(0, 0, 0, 1, 0, 1, 2'b11);
    en = 1;
    // reset mid-frame
    th = 2;
    drive(0, 0, 1, 0, 0, 0, 0);
    push(8'h41); push(8'h42); push(8'h43);
    chk("mr_cause", cause[0], 1);
    chk("mr_level", level, 3);
    rst_n = 0;
    #1;
    chk("mr_level0", level, 0);
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_cause0", cause, 0);
    chk("mr_irq", irq, 0);
    chk("mr_ovf", ovf, 0);
    chk("mr_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    th = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i2c_slv_rx_buffer.md
# i2c_slv_rx_buffer

Receive-side buffer and interrupt generator placed directly downstream of the I2C slave protocol engine in the SoC peripheral domain. It accepts one received byte per strobe from the engine, stores the bytes in a show-ahead FIFO, and tracks frame boundaries from START/STOP events. It raises a maskable interrupt on a FIFO fill threshold or on end-of-frame. Firmware drains the data through the APB register interface, and the interrupt handler copies the stream into L2.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of two and at least 2.
- `LW`, default `$clog2(DEPTH)+1`: width of the level and threshold fields.

Ports:
- `clk_i`, in, 1: SoC clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `byte_valid_i`, in, 1: single-cycle strobe meaning a received byte is present on `byte_data_i`.
- `byte_data_i`, in, 8: received byte.
- `start_i`, in, 1: single-cycle pulse for START or repeated START on the bus.
- `stop_i`, in, 1: single-cycle pulse for STOP on the bus.
- `rd_en_i`, in, 1: pop request from the register interface, one pulse per byte.
- `rd_data_o`, out, 8: FIFO head byte. Valid while `empty_o` is 0.
- `level_o`, out, LW: number of occupied entries.
- `empty_o`, out, 1: FIFO empty.
- `full_o`, out, 1: FIFO full.
- `flush_i`, in, 1: synchronous clear of the FIFO and the overflow flag.
- `thresh_i`, in, LW: fill threshold. A value of 0 disables the threshold cause.
- `irq_en_i`, in, 1: global interrupt enable.
- `irq_clr_i`, in, 2: write-1-to-clear strobes for the cause bits.
- `irq_cause_o`, out, 2: sticky cause bits. Bit 0 is threshold, bit 1 is end-of-frame.
- `irq_o`, out, 1: interrupt request.
- `ovf_o`, out, 1: sticky overflow flag, set when a byte is dropped.
- `frame_cnt_o`, out, 8: bytes received in the current or last frame. Saturates at 255.

## Operation
**Reset values:**
- Pointers 0, `level_o` 0, `empty_o` 1, `full_o` 0.
- `irq_cause_o` 0, `irq_o` 0, `ovf_o` 0, `frame_cnt_o` 0.
- `rd_data_o` 0. Storage is not reset.
- Frame FSM in IDLE.

**FIFO:**
- Push occurs when `byte_valid_i` is 1 and either the FIFO is not full or a pop occurs in the same cycle.
- Pop occurs when `rd_en_i` is 1 and the FIFO is not empty. A pop on an empty FIFO is ignored and has no other effect.
- Push and pop in the same cycle: both succeed and the level is unchanged, including when full. On an empty FIFO, only the push happens.
- Push while full with no pop: the byte is dropped, `ovf_o` sets, and the level is unchanged.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. The level is a separate counter from 0 to DEPTH.
- `flush_i`: pointers and level go to 0 and `ovf_o` clears. `flush_i` wins over a push or pop in the same cycle. Cause bits and frame state are untouched.

**Frame FSM (IDLE, ACTIVE):**
- IDLE to ACTIVE on `start_i`. `frame_cnt_o` clears to 0.
- ACTIVE: each `byte_valid_i` increments `frame_cnt_o`, saturating at 255. Dropped bytes still count.
- ACTIVE to IDLE on `stop_i`. `irq_cause_o[1]` sets if `frame_cnt_o` is greater than 0.
- ACTIVE with `start_i` (repeated START): stays ACTIVE. `irq_cause_o[1]` sets if the count is greater than 0, then `frame_cnt_o` clears.
- `stop_i` in IDLE is ignored.
- `byte_valid_i` in IDLE is still pushed into the FIFO but is not counted.
- `start_i` and `stop_i` in the same cycle: treated as STOP.

**Interrupt:**
- `irq_cause_o[0]` sets in the cycle where `level_q < thresh_i` and `level_d >= thresh_i`, with `thresh_i` not equal to 0. This is rising-edge crossing only; holding at or above the threshold does not re-set the bit after a clear.
- Cause bits are sticky until cleared by the matching `irq_clr_i` bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- `irq_o = irq_en_i & |irq_cause_o`. This is combinational from registered causes. Cause bits still latch while `irq_en_i` is 0.

## Timing
- Push or pop updates the level, flags, `rd_data_o` and `frame_cnt_o` on the next rising edge. Latency is 1 cycle.
- The first byte into an empty FIFO appears on `rd_data_o` one cycle after its `byte_valid_i`.
- A cause bit is visible one cycle after the triggering event. `irq_o` follows in the same cycle the cause bit becomes visible.
- Back-to-back `byte_valid_i` on every cycle is supported.
- Reset asserted mid-frame: all state returns to its reset value immediately. A frame in progress is lost.

## Test plan
- **Single frame:** START, 4 bytes 0x11/0x22/0x33/0x44, STOP, with `irq_en_i`=1 and `thresh_i`=0. Required: `irq_cause_o`=2'b10 one cycle after STOP, `irq_o`=1, `frame_cnt_o`=4. Four pops return 0x11..0x44 in order, then `empty_o`=1.
- **Threshold:** `thresh_i`=3, push 3 bytes. Required: `irq_cause_o[0]` sets on the third push. Clear it, then push a fourth byte: the bit must not re-set. Pop to 2, push back to 3: the bit must re-set.
- **Overflow with DEPTH=8:** push 9 bytes 0x00..0x08 without popping. Required: `full_o`=1, `ovf_o`=1, eight pops return 0x00..0x07, `frame_cnt_o`=9. Then `flush_i` clears `ovf_o` and sets `empty_o`=1.
- **Full with simultaneous push and pop:** with the FIFO full, push 0xAA and pop in the same cycle. Required: level stays 8, no overflow, and 0xAA is the 8th pop.
- **Repeated START:** START, 2 bytes, START, 1 byte, STOP. Required: `irq_cause_o[1]` sets at the second START. After clearing it, the bit sets again at STOP with `frame_cnt_o`=1. STOP alone in IDLE sets nothing.
- **Reset and clear priority:** assert `rst_ni`=0 mid-frame with 3 bytes stored. Required: all outputs return to their reset values at once. In a separate check, `irq_clr_i[1]` in the same cycle as a STOP that sets bit 1 must leave bit 1 set.
